ifu_fetch_ctrl: RTL and testbench

- Fetch sequencer for the instruction fetch unit (IFU).
- Owns the program counter and sequences the external PC incrementer: drives its input and consumes its PC+1 result.
- Runs a req/ack handshake with instruction memory and hands fetched instructions to decode with a valid/ready handshake.
- Applies branch redirects, including redirects that arrive while a memory request is in flight.

---
 rtl/ifu_fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, runs the imem req/ack handshake
// and hands each fetched word to decode over a valid/ready interface.
module ifu_fetch_ctrl #(
    parameter int                   BUS_WIDTH    = 32,
    parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [BUS_WIDTH-1:0] inc_in,
    input  logic [BUS_WIDTH-1:0] inc_out,
    output logic                 imem_req,
    output logic [BUS_WIDTH-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [BUS_WIDTH-1:0] imem_data,
    output logic [BUS_WIDTH-1:0] instr_out,
    output logic [BUS_WIDTH-1:0] instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 stall,
    input  logic                 branch_valid,
    input  logic [BUS_WIDTH-1:0] branch_target
);

    // state | meaning
    // BOOT  | idle after reset, waiting for stall to clear
    // FETCH | request outstanding (imem_req=1) or one-cycle gap after an ack
    // ISSUE | instruction presented to decode
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t               state;
    logic [BUS_WIDTH-1:0] pc;
    logic [BUS_WIDTH-1:0] redirect_addr;
    logic                 redirect_pending;

    assign inc_in = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= BOOT;
            pc               <= RESET_VECTOR;
            redirect_pending <= 1'b0;
            redirect_addr    <= '0;
            imem_req         <= 1'b0;
            imem_addr        <= RESET_VECTOR;
            instr_out        <= '0;
            instr_pc         <= '0;
            instr_valid      <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    if (branch_valid) begin
                        pc <= branch_target;
                    end else if (!stall) begin
                        state     <= FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end

                FETCH: begin
                    if (!imem_req) begin
                        // gap cycle after a discarded ack: no request is out,
                        // so a branch here can retarget the next request directly
                        imem_req <= 1'b1;
                        if (branch_valid) begin
                            pc        <= branch_target;
                            imem_addr <= branch_target;
                        end else begin
                            imem_addr <= pc;
                        end
                    end else if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (redirect_pending || branch_valid) begin
                            redirect_pending <= 1'b0;
                            if (branch_valid) begin
                                pc        <= branch_target;
                                imem_addr <= branch_target;
                            end else begin
                                pc        <= redirect_addr;
                                imem_addr <= redirect_addr;
                            end
                        end else begin
                            instr_out   <= imem_data;
                            instr_pc    <= pc;
                            pc          <= inc_out;
                            imem_addr   <= inc_out;
                            instr_valid <= 1'b1;
                            state       <= ISSUE;
                        end
                    end else if (branch_valid) begin
                        redirect_pending <= 1'b1;
                        redirect_addr    <= branch_target;
                    end
                end

                ISSUE: begin
                    // a redirect is never dropped, even under stall
                    if (branch_valid) begin
                        pc          <= branch_target;
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                        imem_addr   <= branch_target;
                    end else if (instr_ready && !stall) begin
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                        imem_addr   <= pc;
                    end
                end

                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a fetch/decode behavioural model.
module tb_ifu_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] inc_in, inc_out;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_data;
    logic [31:0] instr_out, instr_pc;
    logic        instr_valid, instr_ready, stall, branch_valid;
    logic [31:0] branch_target;

    logic        w_rst, w_req, w_ack, w_valid;
    logic [31:0] w_inc_in, w_inc_out, w_addr, w_data, w_instr, w_ipc;

    assign inc_out   = inc_in + 32'd1;
    assign w_inc_out = w_inc_in + 32'd1;

    ifu_fetch_ctrl #(.BUS_WIDTH(32), .RESET_VECTOR(32'h0)) dut (
        .clk(clk), .rst(rst), .inc_in(inc_in), .inc_out(inc_out),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .stall(stall),
        .branch_valid(branch_valid), .branch_target(branch_target)
    );

    ifu_fetch_ctrl #(.BUS_WIDTH(32), .RESET_VECTOR(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .rst(w_rst), .inc_in(w_inc_in), .inc_out(w_inc_out),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
        .imem_data(w_data), .instr_out(w_instr), .instr_pc(w_ipc),
        .instr_valid(w_valid), .instr_ready(1'b1), .stall(1'b0),
        .branch_valid(1'b0), .branch_target(32'h0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int bad_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the fetch unit must be presenting, in transaction terms.
    logic        m_booted, m_req, m_hold, m_pend;
    logic [31:0] m_pc, m_addr, m_instr, m_ipc, m_raddr;

    task automatic model_reset();
        m_booted = 0; m_req = 0; m_hold = 0; m_pend = 0;
        m_pc = 32'h0; m_addr = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_raddr = 32'h0;
    endtask

    task automatic model_step();
        if (rst) return;
        if (!m_booted) begin
            if (branch_valid) m_pc = branch_target;
            else if (!stall) begin m_booted = 1; m_req = 1; m_addr = m_pc; end
        end else if (m_hold) begin
            if (branch_valid || (instr_ready && !stall)) begin
                if (branch_valid) m_pc = branch_target;
                m_hold = 0; m_req = 1; m_addr = m_pc;
            end
        end else if (!m_req) begin
            if (branch_valid) m_pc = branch_target;
            m_req = 1; m_addr = m_pc;
        end else if (imem_ack) begin
            m_req = 0;
            if (m_pend || branch_valid) begin
                m_pc = branch_valid ? branch_target : m_raddr;
                m_pend = 0;
            end else begin
                m_instr = imem_data; m_ipc = m_pc; m_pc = m_pc + 32'd1; m_hold = 1;
            end
        end else if (branch_valid) begin
            m_pend = 1; m_raddr = branch_target;
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("inc_in", inc_in, m_pc);
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
        if (m_req || !m_booted) chk("imem_addr", imem_addr, m_addr);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_hold});
        chk("instr_out", instr_out, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
        if (instr_valid && instr_out == 32'hBAD) bad_seen++;
    end

    // Stimulus state
    logic        g_ready, g_stall, g_br, prev_req, rand_lat;
    logic [31:0] g_bt;
    int          mem_lat, mem_cnt;
    logic [31:0] dq[$];
    logic [31:0] req_log[$];
    logic [63:0] acc_log[$];

    task automatic clear_logs();
        req_log.delete(); acc_log.delete(); dq.delete();
    endtask

    // Drives one cycle of inputs at a falling edge and returns at the next one.
    task automatic tick();
        logic        a;
        logic [31:0] d;
        a = 1'b0;
        d = $urandom;
        if (imem_req) begin
            if (!prev_req) req_log.push_back(imem_addr);
            if (mem_cnt == 0) begin
                a = 1'b1;
                if (dq.size() > 0) d = dq.pop_front();
            end else mem_cnt--;
        end else begin
            mem_cnt = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
        end
        prev_req = imem_req;
        if (instr_valid && g_ready && !g_stall && !g_br) acc_log.push_back({instr_pc, instr_out});
        imem_ack = a; imem_data = d;
        branch_valid = g_br; branch_target = g_bt; g_br = 1'b0;
        instr_ready = g_ready; stall = g_stall;
        model_step();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        #1 rst = 1'b1;
        #1 chk("rst_req_drop", {31'b0, imem_req}, 32'd0);
        model_reset();
        branch_valid = 1'b0; imem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        prev_req = 1'b0;
        mem_cnt = mem_lat;
        clear_logs();
    endtask

    initial begin
        rst = 1'b1; w_rst = 1'b1;
        imem_ack = 0; imem_data = 0; instr_ready = 0; stall = 0;
        branch_valid = 0; branch_target = 0; w_ack = 0; w_data = 0;
        g_ready = 0; g_stall = 0; g_br = 0; g_bt = 0; prev_req = 0;
        rand_lat = 0; mem_lat = 0; mem_cnt = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_req", {31'b0, imem_req}, 32'd0);
        chk("reset_addr", imem_addr, 32'h0);
        chk("reset_valid", {31'b0, instr_valid}, 32'd0);
        chk("reset_instr", instr_out, 32'h0);
        chk("reset_ipc", instr_pc, 32'h0);

        // Wrap-around instance, RESET_VECTOR = all ones
        w_rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wrap_req0", {31'b0, w_req}, 32'd1);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFF);
        w_ack = 1'b1; w_data = 32'h99;
        @(negedge clk);
        w_ack = 1'b0;
        chk("wrap_valid", {31'b0, w_valid}, 32'd1);
        chk("wrap_ipc", w_ipc, 32'hFFFF_FFFF);
        chk("wrap_instr", w_instr, 32'h99);
        chk("wrap_pc", w_inc_in, 32'h0);
        @(negedge clk);
        chk("wrap_next_req", {31'b0, w_req}, 32'd1);
        chk("wrap_next_addr", w_addr, 32'h0);
        #1 w_rst = 1'b1;
        #1 chk("wrap_rst_req", {31'b0, w_req}, 32'd0);
        @(negedge clk);
        w_rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wrap_restart_req", {31'b0, w_req}, 32'd1);
        chk("wrap_restart_addr", w_addr, 32'hFFFF_FFFF);

        // First fetch after reset, ack latency 2
        rst = 1'b0;
        mem_lat = 2; mem_cnt = 2; g_ready = 1;
        clear_logs();
        dq.push_back(32'hA0);
        for (int i = 0; i < 40 && !(acc_log.size() >= 1 && req_log.size() >= 2); i++) tick();
        chk("t1_done", {31'b0, (acc_log.size() >= 1 && req_log.size() >= 2)}, 32'd1);
        chk("t1_addr0", req_log[0], 32'h0);
        chk("t1_instr", acc_log[0][31:0], 32'hA0);
        chk("t1_ipc", acc_log[0][63:32], 32'h0);
        chk("t1_addr1", req_log[1], 32'h1);

        // Streaming three instructions
        reset_dut();
        mem_lat = 0; mem_cnt = 0; g_ready = 1;
        dq.push_back(32'h11); dq.push_back(32'h22); dq.push_back(32'h33);
        for (int i = 0; i < 40 && acc_log.size() < 3; i++) tick();
        chk("t2_done", acc_log.size(), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk("t2_ipc", acc_log[k][63:32], k);
            chk("t2_instr", acc_log[k][31:0], 32'h11 * (k + 1));
        end

        // Redirects while a fetch is outstanding
        reset_dut();
        mem_lat = 4; mem_cnt = 4; g_ready = 1; bad_seen = 0;
        dq.push_back(32'hBAD); dq.push_back(32'hBAD); dq.push_back(32'h77);
        g_br = 1; g_bt = 32'h5; tick();
        tick(); tick(); tick();
        g_br = 1; g_bt = 32'h40; tick();
        for (int i = 0; i < 20 && req_log.size() < 2; i++) tick();
        g_br = 1; g_bt = 32'h60; tick();
        g_br = 1; g_bt = 32'h80; tick();
        for (int i = 0; i < 20 && req_log.size() < 3; i++) tick();
        for (int i = 0; i < 20 && acc_log.size() < 1; i++) tick();
        chk("t3_addr_a", req_log[0], 32'h5);
        chk("t3_addr_b", req_log[1], 32'h40);
        chk("t3_addr_c", req_log[2], 32'h80);
        chk("t3_acc_pc", acc_log[0][63:32], 32'h80);
        chk("t3_acc_instr", acc_log[0][31:0], 32'h77);
        chk("t3_bad_seen", bad_seen, 32'd0);

        // Branch beats acceptance in ISSUE
        reset_dut();
        mem_lat = 1; mem_cnt = 1; g_ready = 0;
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        chk("t4_issue", {31'b0, instr_valid}, 32'd1);
        g_ready = 1; g_br = 1; g_bt = 32'h100; tick();
        chk("t4_valid", {31'b0, instr_valid}, 32'd0);
        chk("t4_req", {31'b0, imem_req}, 32'd1);
        chk("t4_addr", imem_addr, 32'h100);
        chk("t4_no_accept", acc_log.size(), 32'd0);

        // Stall held in ISSUE
        reset_dut();
        mem_lat = 0; mem_cnt = 0; g_ready = 0;
        dq.push_back(32'h55);
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        g_ready = 1; g_stall = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_valid", {31'b0, instr_valid}, 32'd1);
            chk("t5_instr", instr_out, 32'h55);
            chk("t5_req", {31'b0, imem_req}, 32'd0);
        end
        g_stall = 0; tick();
        chk("t5_accepts", acc_log.size(), 32'd1);
        chk("t5_acc_pc", acc_log[0][63:32], 32'h0);
        chk("t5_next_req", {31'b0, imem_req}, 32'd1);
        chk("t5_next_addr", imem_addr, 32'h1);

        // Randomized traffic
        reset_dut();
        rand_lat = 1;
        for (int i = 0; i < 4000; i++) begin
            g_ready = ($urandom_range(0, 3) != 0);
            g_stall = ($urandom_range(0, 7) == 0);
            g_br    = ($urandom_range(0, 11) == 0);
            g_bt    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 2)) : $urandom;
            if (i % 997 == 500) reset_dut();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
